// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory
//                port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int unsigned DEFAULT_DEPTH = 32;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter (fetch vs. load). The
//                pointer only moves when both requesters contend.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_fetch,
    input  logic i_req_load,
    output logic o_gnt_fetch,
    output logic o_gnt_load
);

    req_t r_ptr;
    logic w_contested;

    assign w_contested = i_req_fetch && i_req_load;

    always_comb begin
        o_gnt_fetch = i_req_fetch && (!i_req_load || (r_ptr == REQ_FETCH));
        o_gnt_load  = i_req_load  && (!i_req_fetch || (r_ptr == REQ_LOAD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= REQ_LOAD;
        end else if (w_contested) begin
            r_ptr <= (r_ptr == REQ_FETCH) ? REQ_LOAD : REQ_FETCH;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_port_arbiter
//  Description : Shares a single-port instruction RAM between core fetch and
//                the program loader; holds the core halted during boot.
//                Optional address checking: define IMEM_BOUNDS_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          FetchReq,
    input  logic [31:0]   FetchAddress,
    output logic          FetchGnt,
    output logic          FetchValid,
    output logic [31:0]   FetchInstruction,
    input  logic          LoadReq,
    input  logic [31:0]   LoadAddress,
    input  logic [31:0]   LoadData,
    output logic          LoadAck,
    input  logic          LoadDone,
    output logic          CoreHalt,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWData,
    input  logic [31:0]   MemRData,
    output logic          AddrError
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_boot;
    logic        w_arb_fetch_req;
    logic        w_fetch_gnt;
    logic        w_load_gnt;
    logic        w_fetch_bad;
    logic        w_load_bad;
    logic        r_rd_pend;
    logic        r_rd_nop;
    logic [31:0] r_instr_hold;
    logic [31:0] w_instr;

    // ------------------------------------------------------------------
    // Boot / run sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == BOOT) && LoadDone) begin
            w_state_nxt = RUN;
        end
    end

    always_comb begin
        w_boot = (r_state == BOOT);
    end

    assign CoreHalt = w_boot;

    // ------------------------------------------------------------------
    // Address qualification
    // ------------------------------------------------------------------
`ifdef IMEM_BOUNDS_CHECK_EN
    logic r_addr_err;

    assign w_fetch_bad = (FetchAddress[1:0] != 2'b00) || ((FetchAddress >> (AW + 2)) != 32'd0);
    assign w_load_bad  = (LoadAddress[1:0]  != 2'b00) || ((LoadAddress  >> (AW + 2)) != 32'd0);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_addr_err <= 1'b0;
        end else if ((w_fetch_gnt && w_fetch_bad) || (w_load_gnt && w_load_bad)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign AddrError = r_addr_err;
`else
    logic w_unused_addr_bits;

    // Upper and byte-offset bits are don't-care: addresses wrap in the RAM.
    assign w_unused_addr_bits = ^{FetchAddress[31:AW+2], FetchAddress[1:0],
                                  LoadAddress[31:AW+2],  LoadAddress[1:0]};
    assign w_fetch_bad        = 1'b0;
    assign w_load_bad         = 1'b0;
    assign AddrError          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration: fetches are masked off entirely while booting
    // ------------------------------------------------------------------
    assign w_arb_fetch_req = FetchReq && !w_boot;

    rr_arbiter2 u_rr_arbiter2 (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .i_req_fetch (w_arb_fetch_req),
        .i_req_load  (LoadReq),
        .o_gnt_fetch (w_fetch_gnt),
        .o_gnt_load  (w_load_gnt)
    );

    assign FetchGnt = w_fetch_gnt;
    assign LoadAck  = w_load_gnt;

    always_comb begin
        MemEn    = 1'b0;
        MemWe    = 1'b0;
        MemAddr  = '0;
        MemWData = '0;
        if (w_load_gnt && !w_load_bad) begin
            MemEn    = 1'b1;
            MemWe    = 1'b1;
            MemAddr  = LoadAddress[AW+1:2];
            MemWData = LoadData;
        end else if (w_fetch_gnt && !w_fetch_bad) begin
            MemEn    = 1'b1;
            MemAddr  = FetchAddress[AW+1:2];
        end
    end

    // ------------------------------------------------------------------
    // Read return: RAM data passes through in the valid cycle, then held
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_nop     <= 1'b0;
            r_instr_hold <= '0;
        end else begin
            r_rd_pend <= w_fetch_gnt;
            r_rd_nop  <= w_fetch_gnt && w_fetch_bad;
            if (r_rd_pend) begin
                r_instr_hold <= w_instr;
            end
        end
    end

    assign w_instr = r_rd_nop ? NOP_WORD : MemRData;

    // A reset arriving while a read is outstanding suppresses its valid.
    assign FetchValid       = r_rd_pend && Reset_n;
    assign FetchInstruction = r_rd_pend ? w_instr : r_instr_hold;

endmodule : imem_port_arbiter
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_port_arbiter
//  Description : Table-driven bench with fetch-return scoreboard and a
//                behavioural single-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          Reset_n;
    logic          FetchReq;
    logic [31:0]   FetchAddress;
    logic          FetchGnt;
    logic          FetchValid;
    logic [31:0]   FetchInstruction;
    logic          LoadReq;
    logic [31:0]   LoadAddress;
    logic [31:0]   LoadData;
    logic          LoadAck;
    logic          LoadDone;
    logic          CoreHalt;
    logic          MemEn;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemWData;
    logic [31:0]   MemRData;
    logic          AddrError;

    imem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .Clock            (clk),
        .Reset_n          (Reset_n),
        .FetchReq         (FetchReq),
        .FetchAddress     (FetchAddress),
        .FetchGnt         (FetchGnt),
        .FetchValid       (FetchValid),
        .FetchInstruction (FetchInstruction),
        .LoadReq          (LoadReq),
        .LoadAddress      (LoadAddress),
        .LoadData         (LoadData),
        .LoadAck          (LoadAck),
        .LoadDone         (LoadDone),
        .CoreHalt         (CoreHalt),
        .MemEn            (MemEn),
        .MemWe            (MemWe),
        .MemAddr          (MemAddr),
        .MemWData         (MemWData),
        .MemRData         (MemRData),
        .AddrError        (AddrError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, 1-cycle read latency
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (MemEn && MemWe) ram[MemAddr] <= MemWData;
        if (MemEn && !MemWe) MemRData <= ram[MemAddr];
    end

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] shadow [DEPTH];
    bit bchk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return bchk && ((a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Scoreboard: every FetchValid must match the oldest expected word
    always @(negedge clk) begin
        if (FetchValid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 64'(FetchInstruction), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("sb_instr", 64'(FetchInstruction), 64'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        lr;
        logic [31:0] la;
        logic [31:0] ld;
        logic        done;
        logic        e_fgnt;
        logic        e_lack;
        logic        e_halt;
    } vec_t;

    vec_t tv [17];

    task automatic drive_idle();
        FetchReq = 0; FetchAddress = 0; LoadReq = 0; LoadAddress = 0; LoadData = 0; LoadDone = 0;
    endtask

    initial begin
        logic        e_men, e_mwe;
        logic [AW-1:0] e_maddr;
        logic [31:0] e_wdata;
        logic [31:0] last_exp;
        logic [31:0] a82;
`ifdef IMEM_BOUNDS_CHECK_EN
        bchk = 1'b1;
`else
        bchk = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        MemRData = '0;
        last_exp = '0;
        Reset_n = 1'b0;
        drive_idle();

        //         fr    fa             lr    la             ld             done  fgnt  lack  halt
        tv[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[1]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[2]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0008, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_000C, 32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0014, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0018, 32'h6666_6666, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0018, 32'h6666_6666, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'h9999_9999, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[10] = '{1'b1, 32'h0000_0014, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[11] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[13] = '{1'b1, 32'h0000_0086, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[14] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[15] = '{1'b1, 32'h0000_0014, 1'b1, 32'h0000_001C, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[16] = '{1'b1, 32'h0000_001C, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 Reset_n = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", 64'({CoreHalt, FetchGnt, LoadAck, FetchValid, MemEn, MemWe, AddrError}), 64'b1000000);
        chk("reset_mem", 64'({MemAddr, MemWData}), 64'd0);
        chk("reset_instr", 64'(FetchInstruction), 64'd0);

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            FetchReq = tv[i].fr; FetchAddress = tv[i].fa;
            LoadReq  = tv[i].lr; LoadAddress  = tv[i].la; LoadData = tv[i].ld;
            LoadDone = tv[i].done;
            @(negedge clk);
            e_men = 0; e_mwe = 0; e_maddr = '0; e_wdata = '0;
            if (tv[i].e_lack && !bad_addr(tv[i].la)) begin
                e_men = 1; e_mwe = 1; e_maddr = AW'(widx(tv[i].la)); e_wdata = tv[i].ld;
            end else if (tv[i].e_fgnt && !bad_addr(tv[i].fa)) begin
                e_men = 1; e_maddr = AW'(widx(tv[i].fa));
            end
            chk($sformatf("vec%0d", i),
                64'({FetchGnt, LoadAck, CoreHalt, MemEn, MemWe, MemAddr, MemWData}),
                64'({tv[i].e_fgnt, tv[i].e_lack, tv[i].e_halt, e_men, e_mwe, e_maddr, e_wdata}));
            if (tv[i].e_fgnt) begin
                last_exp = bad_addr(tv[i].fa) ? NOP : shadow[widx(tv[i].fa)];
                sb_q.push_back(last_exp);
            end
            if (tv[i].e_lack && !bad_addr(tv[i].la)) shadow[widx(tv[i].la)] = tv[i].ld;
        end

        // Hold: instruction persists once FetchValid drops
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("instr_hold", 64'({FetchValid, FetchInstruction}), 64'({1'b0, last_exp}));

        // Reset asserted the cycle after a fetch grant
        @(posedge clk);
        #1 FetchReq = 1; FetchAddress = 32'h8;
        @(negedge clk);
        chk("pre_reset_gnt", 64'(FetchGnt), 64'd1);
        @(posedge clk);
        #1 Reset_n = 0; FetchReq = 0;
        @(negedge clk);
        chk("reset_kill_valid", 64'(FetchValid), 64'd0);
        @(posedge clk);
        #1 Reset_n = 1; FetchReq = 1;
        @(negedge clk);
        chk("post_reset", 64'({CoreHalt, FetchGnt, FetchValid, AddrError, FetchInstruction}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));

        // Back to RUN, then a misaligned/out-of-range fetch
        @(posedge clk);
        #1 FetchReq = 0; LoadDone = 1;
        @(negedge clk);
        @(posedge clk);
        #1 LoadDone = 0; FetchReq = 1; FetchAddress = 32'h82;
        a82 = 32'h82;
        @(negedge clk);
        chk("halt_released", 64'(CoreHalt), 64'd0);
        chk("fetch82_mem", 64'({FetchGnt, MemEn, MemAddr}),
            64'({1'b1, !bad_addr(a82), bad_addr(a82) ? AW'(0) : AW'(widx(a82))}));
        sb_q.push_back(bad_addr(a82) ? NOP : shadow[widx(a82)]);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        chk("addr_err_set", 64'(AddrError), 64'(bchk));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("addr_err_sticky", 64'(AddrError), 64'(bchk));
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_port_arbiter
`default_nettype wire
